// File: rtl/issue_pkg.sv
// Shared constants for the in-order issue stage: unit classes and default widths.
package issue_pkg;

    typedef logic [1:0] unit_t;

    localparam unit_t UNIT_ALU = 2'd0;
    localparam unit_t UNIT_BR  = 2'd1;
    localparam unit_t UNIT_MEM = 2'd2;

    localparam int NREG_DEF  = 32;
    localparam int REG_AW    = $clog2(NREG_DEF);
    localparam int LAT_W_DEF = 3;

endpackage

// File: rtl/issue_launch_scoreboard.sv
// Per-register latency scoreboard: counters drain by one per unstalled cycle,
// launches with a destination reload them, and each slot can query busy/WAW state.
module issue_scoreboard
    import issue_pkg::*;
#(
    parameter int ISSUE_W = 2,
    parameter int NREG    = NREG_DEF,
    parameter int LAT_W   = LAT_W_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               stop,
    input  logic [ISSUE_W*$clog2(NREG)-1:0]    rs1,
    input  logic [ISSUE_W*$clog2(NREG)-1:0]    rs2,
    input  logic [ISSUE_W*$clog2(NREG)-1:0]    rd,
    input  logic [ISSUE_W-1:0]                 we,
    input  logic [ISSUE_W-1:0]                 load,
    input  logic [ISSUE_W*LAT_W-1:0]           lat,
    output logic [ISSUE_W-1:0]                 rs1_idle,
    output logic [ISSUE_W-1:0]                 rs2_idle,
    output logic [ISSUE_W-1:0]                 waw_ok
);

    localparam int AW = $clog2(NREG);

    logic [LAT_W-1:0] cnt [NREG];

    always_comb begin
        rs1_idle = '0;
        rs2_idle = '0;
        waw_ok   = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            rs1_idle[i] = (cnt[rs1[i*AW +: AW]] == '0);
            rs2_idle[i] = (cnt[rs2[i*AW +: AW]] == '0);
            // A new writer may not finish before an older write to the same register.
            waw_ok[i]   = !we[i] || (rd[i*AW +: AW] == '0) ||
                          (cnt[rd[i*AW +: AW]] <= lat[i*LAT_W +: LAT_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else if (!stop) begin
            for (int r = 0; r < NREG; r++) begin
                if (cnt[r] != '0) cnt[r] <= cnt[r] - LAT_W'(1);
            end
            // Later slots are younger, so their load wins on a shared rd.
            for (int i = 0; i < ISSUE_W; i++) begin
                if (load[i] && (rd[i*AW +: AW] != '0)) cnt[rd[i*AW +: AW]] <= lat[i*LAT_W +: LAT_W];
            end
        end
    end

endmodule

// File: rtl/issue_launch.sv
// In-order multi-issue launch stage: operand resolution with writeback forwarding,
// strict-prefix launch select and the registered issue slot bank.
module issue_launch
    import issue_pkg::*;
#(
    parameter int ISSUE_W = 2,
    parameter int NREG    = NREG_DEF,
    parameter int DATA_W  = 32,
    parameter int NFWD    = 4,
    parameter int LAT_W   = LAT_W_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               stop,
    input  logic                               flush,
    input  logic [ISSUE_W-1:0]                 in_valid,
    input  logic [ISSUE_W*$clog2(NREG)-1:0]    in_rs1,
    input  logic [ISSUE_W*$clog2(NREG)-1:0]    in_rs2,
    input  logic [ISSUE_W*$clog2(NREG)-1:0]    in_rd,
    input  logic [ISSUE_W-1:0]                 in_we,
    input  logic [ISSUE_W*LAT_W-1:0]           in_lat,
    input  logic [ISSUE_W*2-1:0]               in_unit,
    input  logic [ISSUE_W*DATA_W-1:0]          rfrd1,
    input  logic [ISSUE_W*DATA_W-1:0]          rfrd2,
    input  logic [NFWD-1:0]                    fwd_valid,
    input  logic [NFWD*$clog2(NREG)-1:0]       fwd_addr,
    input  logic [NFWD*DATA_W-1:0]             fwd_data,
    output logic [$clog2(ISSUE_W):0]           take,
    output logic [ISSUE_W-1:0]                 out_valid,
    output logic [ISSUE_W*2-1:0]               out_unit,
    output logic [ISSUE_W*DATA_W-1:0]          out_rdata1,
    output logic [ISSUE_W*DATA_W-1:0]          out_rdata2
);

    localparam int AW = $clog2(NREG);
    localparam int TW = $clog2(ISSUE_W) + 1;

    logic [ISSUE_W-1:0]         rs1_idle, rs2_idle, waw_ok, launch, load;
    logic [ISSUE_W*LAT_W-1:0]   eff_lat;
    logic [ISSUE_W*2-1:0]       unit_d;
    logic [ISSUE_W*DATA_W-1:0]  data1_d, data2_d;
    logic [DATA_W:0]            op1, op2;
    logic                       ok, can, raw, mem_seen;

    // Returns {ready, data}; the lowest-index forwarding hit wins.
    function automatic logic [DATA_W:0] resolve(input logic [AW-1:0] a, input logic idle,
                                                input logic [DATA_W-1:0] rf);
        logic [DATA_W:0] r;
        r = '0;
        if (a == '0) begin
            r = {1'b1, {DATA_W{1'b0}}};
        end else if (idle) begin
            r = {1'b1, rf};
        end else begin
            for (int p = NFWD - 1; p >= 0; p--) begin
                if (fwd_valid[p] && (fwd_addr[p*AW +: AW] == a)) r = {1'b1, fwd_data[p*DATA_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    always_comb begin
        eff_lat = in_lat;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (in_lat[i*LAT_W +: LAT_W] == '0) eff_lat[i*LAT_W +: LAT_W] = LAT_W'(1);
        end
    end

    issue_scoreboard #(
        .ISSUE_W (ISSUE_W),
        .NREG    (NREG),
        .LAT_W   (LAT_W)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .stop     (stop),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .rd       (in_rd),
        .we       (in_we),
        .load     (load),
        .lat      (eff_lat),
        .rs1_idle (rs1_idle),
        .rs2_idle (rs2_idle),
        .waw_ok   (waw_ok)
    );

    always_comb begin
        launch   = '0;
        take     = '0;
        unit_d   = '0;
        data1_d  = '0;
        data2_d  = '0;
        op1      = '0;
        op2      = '0;
        can      = 1'b0;
        raw      = 1'b0;
        mem_seen = 1'b0;
        ok       = !(rst || stop || flush);
        for (int i = 0; i < ISSUE_W; i++) begin
            op1      = resolve(in_rs1[i*AW +: AW], rs1_idle[i], rfrd1[i*DATA_W +: DATA_W]);
            op2      = resolve(in_rs2[i*AW +: AW], rs2_idle[i], rfrd2[i*DATA_W +: DATA_W]);
            raw      = 1'b0;
            mem_seen = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (in_valid[j] && in_we[j] && (in_rd[j*AW +: AW] != '0) &&
                    ((in_rd[j*AW +: AW] == in_rs1[i*AW +: AW]) ||
                     (in_rd[j*AW +: AW] == in_rs2[i*AW +: AW])))
                    raw = 1'b1;
                if (in_unit[j*2 +: 2] == UNIT_MEM) mem_seen = 1'b1;
            end
            can = in_valid[i] && op1[DATA_W] && op2[DATA_W] && !raw && waw_ok[i] &&
                  !((in_unit[i*2 +: 2] == UNIT_MEM) && mem_seen);
            // Once one slot blocks, every younger slot stays blocked.
            ok        = ok && can;
            launch[i] = ok;
            if (ok) begin
                take                       = take + TW'(1);
                unit_d[i*2 +: 2]           = in_unit[i*2 +: 2];
                data1_d[i*DATA_W +: DATA_W] = op1[DATA_W-1:0];
                data2_d[i*DATA_W +: DATA_W] = op2[DATA_W-1:0];
            end
        end
    end

    assign load = launch & in_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= '0;
            out_unit   <= '0;
            out_rdata1 <= '0;
            out_rdata2 <= '0;
        end else if (flush) begin
            out_valid  <= '0;
        end else if (!stop) begin
            out_valid  <= launch;
            out_unit   <= unit_d;
            out_rdata1 <= data1_d;
            out_rdata2 <= data2_d;
        end
    end

endmodule

// File: tb/tb_issue_launch.sv
// Directed bench for issue_launch (ISSUE_W=2): hand-computed takes, issued
// operands and scoreboard counts across RAW, latency, WAW, MEM, stop, flush, reset.
module tb_issue_launch;
    import issue_pkg::*;

    localparam int IW = 2, NREG = 32, DW = 32, NF = 4, LW = 3, AW = 5;

    logic              clk = 1'b0;
    logic              rst, stop, flush;
    logic [IW-1:0]     in_valid, in_we;
    logic [IW*AW-1:0]  in_rs1, in_rs2, in_rd;
    logic [IW*LW-1:0]  in_lat;
    logic [IW*2-1:0]   in_unit;
    logic [IW*DW-1:0]  rfrd1, rfrd2;
    logic [NF-1:0]     fwd_valid;
    logic [NF*AW-1:0]  fwd_addr;
    logic [NF*DW-1:0]  fwd_data;
    logic [1:0]        take;
    logic [IW-1:0]     out_valid;
    logic [IW*2-1:0]   out_unit;
    logic [IW*DW-1:0]  out_rdata1, out_rdata2;

    int checks = 0, failures = 0;
    logic [LW-1:0] cnt_or;

    issue_launch #(.ISSUE_W(IW), .NREG(NREG), .DATA_W(DW), .NFWD(NF), .LAT_W(LW)) dut (
        .clk(clk), .rst(rst), .stop(stop), .flush(flush),
        .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_we(in_we), .in_lat(in_lat), .in_unit(in_unit),
        .rfrd1(rfrd1), .rfrd2(rfrd2),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .take(take), .out_valid(out_valid), .out_unit(out_unit),
        .out_rdata1(out_rdata1), .out_rdata2(out_rdata2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr();
        in_valid = '0; in_we = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_lat = '0; in_unit = '0; rfrd1 = '0; rfrd2 = '0;
        fwd_valid = '0; fwd_addr = '0; fwd_data = '0;
    endtask

    task automatic slot(input int i, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic [AW-1:0] rd, input logic we, input logic [LW-1:0] lat,
                        input logic [1:0] unit, input logic [DW-1:0] rf1, input logic [DW-1:0] rf2);
        in_valid[i] = 1'b1;
        in_rs1[i*AW +: AW] = rs1;
        in_rs2[i*AW +: AW] = rs2;
        in_rd[i*AW +: AW]  = rd;
        in_we[i]           = we;
        in_lat[i*LW +: LW] = lat;
        in_unit[i*2 +: 2]  = unit;
        rfrd1[i*DW +: DW]  = rf1;
        rfrd2[i*DW +: DW]  = rf2;
    endtask

    task automatic fwd(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        fwd_valid[p] = 1'b1;
        fwd_addr[p*AW +: AW] = a;
        fwd_data[p*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stop = 1'b0; flush = 1'b0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        slot(0, 0, 0, 1, 1, 1, UNIT_ALU, 32'h1, 0);
        #1;
        chk("rst_take", take, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_rdata1", out_rdata1, 0);
        chk("rst_cnt1", dut.u_sb.cnt[1], 0);
        rst = 1'b0;
        clr();

        // independent pair
        slot(0, 10, 11, 1, 1, 1, UNIT_ALU, 32'h11, 0);
        slot(1, 12, 13, 2, 1, 1, UNIT_ALU, 32'h22, 0);
        #1;
        chk("pair_take", take, 2);
        tick();
        chk("pair_valid", out_valid, 2'b11);
        chk("pair_rdata1", out_rdata1, 64'h00000022_00000011);
        chk("pair_cnt1", dut.u_sb.cnt[1], 1);
        clr();
        tick();
        chk("idle_valid", out_valid, 0);
        chk("idle_cnt2", dut.u_sb.cnt[2], 0);

        // intra-bundle RAW, then forwarded operand; x0 reads as zero
        slot(0, 0, 0, 5, 1, 1, UNIT_ALU, 32'h77, 0);
        slot(1, 5, 0, 6, 1, 1, UNIT_ALU, 32'h55, 0);
        #1;
        chk("raw_take", take, 1);
        tick();
        chk("raw_valid", out_valid, 2'b01);
        chk("raw_x0_data", out_rdata1, 0);
        clr();
        slot(0, 5, 0, 6, 1, 1, UNIT_ALU, 32'h999, 0);
        fwd(2, 5, 32'hABCD);
        fwd(3, 5, 32'h5555);
        #1;
        chk("fwd_take", take, 1);
        tick();
        chk("fwd_rdata1", out_rdata1, 64'h0000ABCD);
        chk("fwd_cnt6", dut.u_sb.cnt[6], 1);
        clr();
        tick();

        // latency-3 producer, consumer stalls two cycles
        slot(0, 0, 0, 7, 1, 3, UNIT_MEM, 0, 0);
        #1;
        chk("lat_take_ld", take, 1);
        tick();
        chk("lat_cnt7_3", dut.u_sb.cnt[7], 3);
        clr();
        slot(0, 7, 0, 8, 1, 1, UNIT_ALU, 32'h1, 0);
        #1;
        chk("lat_stall1", take, 0);
        tick();
        chk("lat_cnt7_2", dut.u_sb.cnt[7], 2);
        chk("lat_stall2", take, 0);
        chk("lat_stall_valid", out_valid, 0);
        tick();
        chk("lat_nofwd", take, 0);
        fwd(1, 7, 32'h7777);
        #1;
        chk("lat_fwd_take", take, 1);
        tick();
        chk("lat_rdata1", out_rdata1, 64'h00007777);
        chk("lat_cnt7_0", dut.u_sb.cnt[7], 0);
        clr();
        tick();

        // WAW: new writer lat 0 (treated as 1) waits for cnt[x3] <= 1
        slot(0, 0, 0, 3, 1, 3, UNIT_ALU, 0, 0);
        tick();
        clr();
        slot(0, 0, 0, 3, 1, 0, UNIT_ALU, 0, 0);
        #1;
        chk("waw_blk3", take, 0);
        tick();
        chk("waw_blk2", take, 0);
        tick();
        chk("waw_ok1", take, 1);
        tick();
        chk("waw_cnt3", dut.u_sb.cnt[3], 1);
        clr();

        // two MEM slots, then stop held for 3 cycles
        slot(0, 0, 0, 9, 1, 4, UNIT_MEM, 0, 0);
        slot(1, 0, 0, 0, 0, 1, UNIT_MEM, 0, 0);
        #1;
        chk("mem_take", take, 1);
        tick();
        chk("mem_valid", out_valid, 2'b01);
        chk("mem_unit", out_unit, 4'b0010);
        clr();
        stop = 1'b1;
        slot(0, 0, 0, 0, 0, 1, UNIT_BR, 32'h33, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stop_take", take, 0);
            tick();
            chk("stop_valid", out_valid, 2'b01);
            chk("stop_unit", out_unit, 4'b0010);
            chk("stop_cnt9", dut.u_sb.cnt[9], 4);
        end
        stop = 1'b0;
        clr();
        tick();
        chk("unstop_cnt9", dut.u_sb.cnt[9], 3);
        chk("unstop_valid", out_valid, 0);

        // flush alone, then flush together with stop
        slot(0, 0, 0, 0, 0, 1, UNIT_BR, 32'h1, 0);
        slot(1, 0, 0, 0, 0, 1, UNIT_ALU, 32'h2, 0);
        tick();
        chk("pre_flush_valid", out_valid, 2'b11);
        clr();
        slot(0, 0, 0, 10, 1, 2, UNIT_ALU, 0, 0);
        slot(1, 0, 0, 11, 1, 2, UNIT_ALU, 0, 0);
        flush = 1'b1;
        #1;
        chk("flush_take", take, 0);
        tick();
        chk("flush_valid", out_valid, 0);
        chk("flush_cnt10", dut.u_sb.cnt[10], 0);
        flush = 1'b0;
        #1;
        chk("post_flush_take", take, 2);
        tick();
        chk("post_flush_valid", out_valid, 2'b11);
        chk("post_flush_cnt10", dut.u_sb.cnt[10], 2);
        flush = 1'b1;
        stop = 1'b1;
        tick();
        chk("flush_stop_valid", out_valid, 0);
        chk("flush_stop_cnt10", dut.u_sb.cnt[10], 2);
        flush = 1'b0;
        stop = 1'b0;
        clr();

        // reset in the middle of a stall
        slot(0, 20, 0, 12, 1, 5, UNIT_BR, 32'hDEAD, 32'hBEEF);
        tick();
        chk("pre_rst_rdata1", out_rdata1, 64'h0000DEAD);
        chk("pre_rst_unit", out_unit, 4'b0001);
        clr();
        slot(0, 12, 0, 13, 1, 1, UNIT_ALU, 0, 0);
        slot(1, 0, 0, 0, 0, 1, UNIT_ALU, 0, 0);
        rst = 1'b1;
        #1;
        chk("rst_mid_take", take, 0);
        tick();
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_unit", out_unit, 0);
        chk("rst_mid_rdata1", out_rdata1, 0);
        chk("rst_mid_rdata2", out_rdata2, 0);
        cnt_or = '0;
        for (int r = 0; r < NREG; r++) cnt_or = cnt_or | dut.u_sb.cnt[r];
        chk("rst_mid_cnt_all", cnt_or, 0);
        rst = 1'b0;
        clr();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/issue_launch.md
# issue_launch

Parametrised in-order issue stage for the multi-issue core. Sits between decode and the execution units and takes up to ISSUE_W decoded instructions per cycle. Uses a per-register latency scoreboard and writeback forwarding to decide how many of them launch. Issued instructions, with their resolved operands, go into a registered issue slot bank.

## Interface
Parameters:
- ISSUE_W, 2, decode/issue slots per cycle (1..4)
- NREG, 32, architectural registers; register 0 hard-wired zero
- DATA_W, 32, operand width
- NFWD, 4, forwarding/writeback ports
- LAT_W, 3, scoreboard counter width; max latency 2^LAT_W-1

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- stop  in  1  downstream stall; freezes issue register and scoreboard
- flush  in  1  kill contents of issue register
- in_valid  in  ISSUE_W  decoded slot valid (slot 0 oldest)
- in_rs1, in_rs2, in_rd  in  ISSUE_W*log2(NREG)  register addresses per slot
- in_we  in  ISSUE_W  slot writes rd
- in_lat  in  ISSUE_W*LAT_W  execute latency of slot; 0 treated as 1
- in_unit  in  ISSUE_W*2  unit class (ALU/BR/MEM)
- rfrd1, rfrd2  in  ISSUE_W*DATA_W  regfile read data for rs1/rs2 per slot
- fwd_valid  in  NFWD  result present on port
- fwd_addr  in  NFWD*log2(NREG)  destination register
- fwd_data  in  NFWD*DATA_W  result value
- take  out  log2(ISSUE_W)+1  number of slots accepted this cycle (combinational)
- out_valid  out  ISSUE_W  issued slot valid (registered)
- out_unit  out  ISSUE_W*2  unit class of issued slot
- out_rdata1, out_rdata2  out  ISSUE_W*DATA_W  resolved operands

## Operation
- Operand ready: address 0 is always ready, with data 0. Otherwise ready if scoreboard cnt[r]==0 (use rfrd). Otherwise ready if any fwd port hits r, using the data of the lowest-index hitting port. Otherwise not ready.
- Slot i launchable when all of the following hold:
  - in_valid[i];
  - both operands ready;
  - no RAW on rs1/rs2 against the rd of an earlier slot with we in the same bundle;
  - no WAW: for we and rd!=0, cnt[rd] <= effective lat;
  - MEM class appears at most once among launched slots.
- Issue is strict in-order prefix: take = number of leading launchable slots; slots after the first blocked slot never launch.
- When stop=1: take=0, and the issue register, scoreboard and fwd use are ignored/held.
- Scoreboard:
  - Each cycle with stop=0, every nonzero cnt decrements by 1.
  - A launched slot with we and rd!=0 loads cnt[rd]=lat. The load overrides the decrement.
  - The result is expected on a fwd port while cnt==1; cnt==0 means the regfile holds it.
- Issue register: on stop=0, out_* load the launched slots, compacted to slot 0..take-1, and unused out_valid bits are 0.
- Flush: on flush=1, out_valid is cleared next edge and take=0 that cycle. The scoreboard is not cleared, because counters drain naturally, which is conservatively safe.
- flush has priority over stop. rst has priority over all.

## Timing
- Launch decision and take: combinational in cycle N. Issued slot visible on out_* in cycle N+1.
- Back-to-back dependency at lat=1 issues in consecutive cycles via forwarding. lat=k adds k-1 stall cycles.
- Reset values: out_valid=0, out_unit=0, out_rdata*=0, all cnt=0. take=0 while rst=1.
- rst asserted mid-operation clears all state at the next edge, with no partial issue.

## Structure
- Shared package issue_pkg: unit class constants (UNIT_ALU=2'd0, UNIT_BR=2'd1, UNIT_MEM=2'd2), register-address width, LAT_W default.
- Sub-module issue_scoreboard: NREG counters, decrement/load logic, and a per-slot busy/WAW query. issue_launch holds the select, forwarding mux and issue register.

## Test plan
- Independent pair, ISSUE_W=2: slot0 add x1 and slot1 add x2, registers idle, rfrd=0x11/0x22 -> take=2. Next cycle out_valid=2'b11, with out_rdata1 carrying the rfrd values.
- Intra-bundle RAW: slot0 writes x5 and slot1 reads x5 -> take=1, and only slot0 issues. Next cycle slot1 is presented as slot0 with fwd x5=0xABCD -> it issues with operand 0xABCD.
- Latency stall: load x7 with lat=3, then a consumer of x7 -> consumer stalled for 2 cycles. It issues when fwd hits x7, and cnt[x7] reaches 0 one cycle after.
- WAW: cnt[x3]=3, new ALU writing x3 with lat=1 -> blocked until cnt[x3]<=1.
- Two MEM slots in one bundle -> take=1. stop held for 3 cycles -> out_* and counters unchanged.
- flush coincident with a valid launch -> out_valid=0 next cycle and take=0. rst mid-stall -> all outputs 0 and all cnt 0 next cycle.
